// File: rtl/lc3_mem_access_unit.sv
// LC-3 MAR/MDR register pair with a single-outstanding req/ack memory handshake engine.
// A transaction is started by MIO.EN in IDLE, holds req in BUSY until ack or timeout,
// and reports completion with a one-cycle R pulse in DONE.
module lc3_mem_access_unit #(
  parameter logic [15:0] MMIO_BASE   = 16'hFE00,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_bus,
  input  logic        i_ld_mar,
  input  logic        i_ld_mdr,
  input  logic        i_mio_en,
  input  logic        i_rw,
  output logic [15:0] o_mar,
  output logic [15:0] o_mdr,
  output logic        o_R,
  output logic        o_err,
  output logic        o_mmio_sel,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Last BUSY cycle count value before the transaction is abandoned.
  localparam logic [7:0] CntLast = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  // Next-state and register update logic; MAR/MDR only accept bus loads while idle.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_ld_mar) mar_d = i_bus;
        // With MIO.EN set the MDR source is memory, so the bus load is suppressed.
        if (i_ld_mdr && !i_mio_en) mdr_d = i_bus;
        if (i_mio_en) begin
          state_d = StBusy;
          we_d    = i_rw;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StBusy: begin
        // An ack arriving in the final timeout cycle still completes cleanly.
        if (i_mem_ack) begin
          if (!we_q) rdata_d = i_mem_rdata;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        if (!we_q && i_ld_mdr) mdr_d = err_q ? 16'h0000 : rdata_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mdr_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode directly from registered state so req drops as soon as reset asserts.
  always_comb begin
    o_mar       = mar_q;
    o_mdr       = mdr_q;
    o_R         = (state_q == StDone);
    o_err       = (state_q == StDone) && err_q;
    o_mem_req   = (state_q == StBusy);
    o_mem_we    = (state_q == StBusy) && we_q;
    o_mem_addr  = mar_q;
    o_mem_wdata = mdr_q;
    o_mmio_sel  = (mar_q >= MMIO_BASE);
  end

endmodule

// File: tb/tb_lc3_mem_access_unit.sv
// Directed bench for lc3_mem_access_unit: a transaction-level model is checked against the
// DUT every cycle, and literal expectations pin latency, data and reset behaviour.
module tb_lc3_mem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] bus;
  logic        ld_mar, ld_mdr, mio_en, rw;
  logic [15:0] o_mar, o_mdr, o_mem_addr, o_mem_wdata;
  logic        o_R, o_err, o_mmio_sel, o_mem_req, o_mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int tests = 0;
  int errors = 0;

  lc3_mem_access_unit #(
    .MMIO_BASE  (16'hFE00),
    .ACK_TIMEOUT(TO)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_bus      (bus),
    .i_ld_mar   (ld_mar),
    .i_ld_mdr   (ld_mdr),
    .i_mio_en   (mio_en),
    .i_rw       (rw),
    .o_mar      (o_mar),
    .o_mdr      (o_mdr),
    .o_R        (o_R),
    .o_err      (o_err),
    .o_mmio_sel (o_mmio_sel),
    .o_mem_req  (o_mem_req),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata),
    .i_mem_ack  (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level reference: registers plus one in-flight access tracked by its age.
  logic [15:0] m_mar = '0, m_mdr = '0, m_rdata = '0;
  bit          m_inflight = 0, m_fin = 0, m_we = 0, m_err = 0;
  int          m_age = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mar <= '0; m_mdr <= '0; m_rdata <= '0;
      m_inflight <= 0; m_fin <= 0; m_we <= 0; m_err <= 0; m_age <= 0;
    end else if (m_fin) begin
      if (!m_we && ld_mdr) m_mdr <= m_err ? 16'h0000 : m_rdata;
      m_fin <= 0;
    end else if (m_inflight) begin
      m_age <= m_age + 1;
      if (mem_ack || (m_age + 1 == TO)) begin
        m_inflight <= 0;
        m_fin      <= 1;
        m_err      <= !mem_ack;
        if (mem_ack && !m_we) m_rdata <= mem_rdata;
      end
    end else begin
      if (ld_mar) m_mar <= bus;
      if (ld_mdr && !mio_en) m_mdr <= bus;
      if (mio_en) begin
        m_inflight <= 1;
        m_age      <= 0;
        m_we       <= rw;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("mar", o_mar, m_mar);
    chk("mdr", o_mdr, m_mdr);
    chk("R", 16'(o_R), 16'(m_fin));
    chk("err", 16'(o_err), 16'(m_fin && m_err));
    chk("mem_req", 16'(o_mem_req), 16'(m_inflight));
    chk("mem_we", 16'(o_mem_we), 16'(m_inflight && m_we));
    chk("mem_addr", o_mem_addr, m_mar);
    chk("mem_wdata", o_mem_wdata, m_mdr);
    chk("mmio_sel", 16'(o_mmio_sel), 16'(m_mar >= 16'hFE00));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one access; lat counts edges from MIO.EN being sampled to R being visible.
  task automatic access(input bit we, input int ack_after, input logic [15:0] rd,
                        input bit ldmdr, input bit freeze, output int lat, output bit err);
    int n;
    n = 0;
    mio_en = 1; rw = we; ld_mdr = ldmdr;
    step();
    mio_en = 0;
    lat = 1;
    chk("req_after_mio", 16'(o_mem_req), 16'd1);
    if (freeze) begin
      ld_mar = 1;
      bus    = 16'h5555;
    end
    while (o_R !== 1'b1 && lat < 20) begin
      mem_ack   = (n == ack_after);
      mem_rdata = rd;
      step();
      mem_ack = 0;
      lat++;
      n++;
    end
    if (lat >= 20) begin
      errors++;
      $display("FAIL r_wait: got no R pulse, expected one within 20 cycles");
    end
    err = o_err;
    step();
    ld_mar = 0; ld_mdr = 0;
  endtask

  int          lat;
  bit          err;
  int          rcount;
  logic [15:0] mmio_addr [3];
  logic [15:0] mmio_exp [3];

  initial begin
    rst_n = 0; bus = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; rw = 0;
    mem_rdata = '0; mem_ack = 0;
    repeat (2) step();
    rst_n = 1;
    chk("rst_mar", o_mar, 16'h0000);
    chk("rst_mdr", o_mdr, 16'h0000);
    chk("rst_R", 16'(o_R), 16'd0);
    chk("rst_req", 16'(o_mem_req), 16'd0);

    // Read with ack on the third request cycle.
    bus = 16'h3000; ld_mar = 1; step(); ld_mar = 0;
    access(0, 2, 16'hBEEF, 1, 0, lat, err);
    chk("read_lat", 16'(lat), 16'd4);
    chk("read_err", 16'(err), 16'd0);
    chk("read_mdr", o_mdr, 16'hBEEF);

    // Write, with MAR load attempts during BUSY that must be ignored.
    bus = 16'h4001; ld_mar = 1; step();
    bus = 16'h1234; ld_mar = 0; ld_mdr = 1; step(); ld_mdr = 0;
    access(1, 1, 16'hDEAD, 1, 1, lat, err);
    chk("write_lat", 16'(lat), 16'd3);
    chk("write_mdr", o_mdr, 16'h1234);
    chk("freeze_mar", o_mar, 16'h4001);

    // Timeout on a read clears MDR.
    bus = 16'hAAAA; ld_mdr = 1; step(); ld_mdr = 0;
    access(0, -1, 16'h0000, 1, 0, lat, err);
    chk("to_lat", 16'(lat), 16'd5);
    chk("to_err", 16'(err), 16'd1);
    chk("to_mdr", o_mdr, 16'h0000);

    // Ack in the last allowed cycle wins over the timeout.
    access(0, 3, 16'h0F0F, 1, 0, lat, err);
    chk("lastack_lat", 16'(lat), 16'd5);
    chk("lastack_err", 16'(err), 16'd0);
    chk("lastack_mdr", o_mdr, 16'h0F0F);

    // I/O page boundary.
    mmio_addr[0] = 16'hFDFF; mmio_exp[0] = 16'd0;
    mmio_addr[1] = 16'hFE00; mmio_exp[1] = 16'd1;
    mmio_addr[2] = 16'hFFFF; mmio_exp[2] = 16'd1;
    for (int i = 0; i < 3; i++) begin
      bus = mmio_addr[i]; ld_mar = 1; step(); ld_mar = 0;
      chk("mmio_lit", 16'(o_mmio_sel), mmio_exp[i]);
    end

    // Back-to-back reads with MIO.EN and ack held: two R pulses in six cycles.
    rcount = 0;
    mio_en = 1; rw = 0; ld_mdr = 1; mem_ack = 1; mem_rdata = 16'h1111;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 4) mio_en = 0;
      rcount += int'(o_R);
    end
    mem_ack = 0; ld_mdr = 0;
    chk("b2b_rcount", 16'(rcount), 16'd2);
    chk("b2b_mdr", o_mdr, 16'h1111);

    // Asynchronous reset in the middle of a transaction.
    bus = 16'h2222; ld_mar = 1; step(); ld_mar = 0;
    mio_en = 1; step(); mio_en = 0;
    chk("pre_rst_req", 16'(o_mem_req), 16'd1);
    rst_n = 0;
    #1;
    chk("midrst_req", 16'(o_mem_req), 16'd0);
    chk("midrst_R", 16'(o_R), 16'd0);
    chk("midrst_mar", o_mar, 16'h0000);
    chk("midrst_mdr", o_mdr, 16'h0000);
    step();
    rst_n = 1;
    step();
    chk("postrst_R", 16'(o_R), 16'd0);
    chk("postrst_req", 16'(o_mem_req), 16'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
